// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// access-size encodings and the data_memory geometry.
package lsu_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 8;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_HALF = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        ISSUE1,
        CAPT0,
        CAPT1,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// Byte/halfword load-store unit sequencing a byte-wide data_memory with registered reads.
// Halfword support is compiled in only when LSU_HALFWORD_EN is defined.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_size,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

`ifdef LSU_HALFWORD_EN
    localparam int WD_W = 2 * DATA_W;
`else
    localparam int WD_W = DATA_W;
`endif

    lsu_state_e           state_q, state_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [WD_W-1:0]      wdata_q, wdata_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic                 mem_we_q, mem_we_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]    rdata_lo_q, rdata_lo_d;

`ifdef LSU_HALFWORD_EN
    logic                 size_q, size_d;
    logic [DATA_W-1:0]    rdata_hi_q, rdata_hi_d;
    logic [ADDR_W-1:0]    addr_inc;

    // Second byte address wraps naturally at the top of the address space.
    assign addr_inc  = addr_q + ADDR_W'(1);
    assign rsp_rdata = {rdata_hi_q, rdata_lo_q};
`else
    logic                 unused_ok;

    assign unused_ok = ^{req_size, req_wdata[2*DATA_W-1:DATA_W]};
    assign rsp_rdata = {{DATA_W{1'b0}}, rdata_lo_q};
`endif

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

    // Memory-side signals are registered so they line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        rdata_lo_d  = rdata_lo_q;
`ifdef LSU_HALFWORD_EN
        size_d      = size_q;
        rdata_hi_d  = rdata_hi_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = ISSUE0;
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata[WD_W-1:0];
                    mem_addr_d  = req_addr;
                    mem_we_d    = req_we;
                    mem_wdata_d = req_wdata[DATA_W-1:0];
                    rdata_lo_d  = '0;
`ifdef LSU_HALFWORD_EN
                    size_d      = req_size;
                    rdata_hi_d  = '0;
`endif
                end
            end
            ISSUE0: begin
                state_d = RESP;
                if (!we_q) begin
                    state_d = CAPT0;
`ifdef LSU_HALFWORD_EN
                    // Present the upper address during CAPT0 so both reads overlap.
                    if (size_q == SIZE_HALF) begin
                        mem_addr_d = addr_inc;
                    end
`endif
                end
`ifdef LSU_HALFWORD_EN
                else if (size_q == SIZE_HALF) begin
                    state_d     = ISSUE1;
                    mem_addr_d  = addr_inc;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = wdata_q[2*DATA_W-1:DATA_W];
                end
`endif
            end
`ifdef LSU_HALFWORD_EN
            ISSUE1: begin
                state_d = RESP;
            end
            CAPT1: begin
                rdata_hi_d = mem_rdata;
                state_d    = RESP;
            end
`endif
            CAPT0: begin
                rdata_lo_d = mem_rdata;
                state_d    = RESP;
`ifdef LSU_HALFWORD_EN
                if (size_q == SIZE_HALF) begin
                    state_d = CAPT1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rdata_lo_q  <= '0;
`ifdef LSU_HALFWORD_EN
            size_q      <= SIZE_BYTE;
            rdata_hi_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_lo_q  <= rdata_lo_d;
`ifdef LSU_HALFWORD_EN
            size_q      <= size_d;
            rdata_hi_q  <= rdata_hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a byte-wide registered-read
// data_memory responder; expectations follow the LSU_HALFWORD_EN build setting.
module tb_load_store_unit;

`ifdef LSU_HALFWORD_EN
    localparam bit HW_EN = 1'b1;
`else
    localparam bit HW_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_size = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [15:0] req_wdata = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  dmem [256];
    logic [7:0]  ref_mem [256];
    logic        mem_loaded = 1'b0;

    typedef struct {
        logic [15:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // data_memory responder: one-cycle registered read, write on mem_we.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 8'(i) ^ 8'h5A;
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            dmem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= dmem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic sz, input logic [7:0] a, input logic [15:0] wd);
        exp_t       e;
        exp_t       got;
        bit         hw;
        bit         acc;
        int         lat;
        logic [7:0] a1;
        a1 = a + 8'd1;
        hw = HW_EN && sz;
        e.lat = we ? (hw ? 3 : 2) : (hw ? 4 : 3);
        if (we) begin
            e.rdata = 16'h0000;
            ref_mem[a] = wd[7:0];
            if (hw) ref_mem[a1] = wd[15:8];
        end else begin
            e.rdata = hw ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
        end
        sb.push_back(e);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (req_ready) acc = 1'b1;
            step();
        end
        req_valid = 1'b0;
        got = sb.pop_front();
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("latency", 32'(lat), 32'(got.lat));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(got.rdata));
        $display("txn we=%0d size=%0d addr=%02h wdata=%04h rdata=%04h latency=%0d",
                 we, sz, a, wd, rsp_rdata, lat);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_after_ack", 32'(rsp_valid), 32'd0);
        chk("req_ready_after_ack", 32'(req_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

        // Asynchronous reset: outputs must clear before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        send(1'b1, 1'b0, 8'h10, 16'h00A5); ack();
        send(1'b0, 1'b0, 8'h10, 16'h0000); ack();

        send(1'b1, 1'b1, 8'h20, 16'hBEEF); ack();
        chk("mem_20", 32'(dmem[8'h20]), 32'(ref_mem[8'h20]));
        chk("mem_21", 32'(dmem[8'h21]), 32'(ref_mem[8'h21]));
        send(1'b0, 1'b1, 8'h20, 16'h0000); ack();

        send(1'b1, 1'b1, 8'hFF, 16'h1234); ack();
        chk("mem_ff", 32'(dmem[8'hFF]), 32'(ref_mem[8'hFF]));
        chk("mem_00", 32'(dmem[8'h00]), 32'(ref_mem[8'h00]));
        send(1'b0, 1'b1, 8'hFF, 16'h0000); ack();

        // Back-pressure: response held, a new request pending but not accepted.
        send(1'b0, 1'b0, 8'h10, 16'h0000);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 1'b0;
        req_addr  = 8'h40;
        req_wdata = 16'h0033;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_rdata", 32'(rsp_rdata), 32'(ref_mem[8'h10]));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        ack();
        send(1'b1, 1'b0, 8'h40, 16'h0033); ack();
        send(1'b0, 1'b0, 8'h40, 16'h0000); ack();

        // Reset pulse during the second write cycle of a halfword store.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 1'b1;
        req_addr  = 8'h30;
        req_wdata = 16'h5678;
        step();
        req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        rst_n = 1'b1;
        ref_mem[8'h30] = 8'h78;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("abort_mem_30", 32'(dmem[8'h30]), 32'h78);
        chk("abort_mem_31", 32'(dmem[8'h31]), 32'(ref_mem[8'h31]));

        send(1'b0, 1'b1, 8'h30, 16'h0000); ack();
        send(1'b1, 1'b0, 8'h50, 16'h00C3); ack();
        send(1'b0, 1'b0, 8'h50, 16'h0000); ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
